// File: rtl/mc_core_if.sv
// Instruction and data request/acknowledge buses of the multi-cycle core.
// The master side belongs to the core and the slave side to the memory models.
interface mc_core_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  i_ack, i_rdata, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    output i_ack, i_rdata, d_ack, d_rdata
  );
endinterface

// File: rtl/mc_core.sv
// Multi-cycle RV32I/RV32E core with FETCH -> EXEC -> (MEM) -> FETCH sequencing.
// It halts on EBREAK, and it also halts on an illegal instruction when HALT_ILL is 1.
module mc_core #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NREG     = 32,
  parameter bit          HALT_ILL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  mc_core_if.master   bus,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halt,
  output logic        illegal
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam int         IW        = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG_W    = 6'(NREG);

  state_t      state;
  logic [31:0] ir;
  logic [1:0]  ld_off;
  logic [31:0] rf [NREG];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, op_b, alu_res, wr_val, next_pc, mem_addr;
  logic [31:0] st_data, ld_shift, ld_val, rf_wdata;
  logic [3:0]  st_strb;
  logic        wr_en, taken, ill, is_mem, is_store, is_ebreak;
  logic        use_rs1, use_rs2, use_rd, br_cond, exec_commit, rf_we;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // x0 and out-of-range indices read as zero; the out-of-range case is flagged illegal below.
  assign rs1_val = (rs1 == 5'd0 || {1'b0, rs1} >= NREG_W) ? 32'd0 : rf[rs1[IW-1:0]];
  assign rs2_val = (rs2 == 5'd0 || {1'b0, rs2} >= NREG_W) ? 32'd0 : rf[rs2[IW-1:0]];

  assign bus.i_addr = pc;
  assign mem_addr   = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  // Shared ALU for OP and OP-IMM; ir[30] selects SUB only for OP and selects SRA for both.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    op_b    = (opcode == OP_OP) ? rs2_val : imm_i;
    alu_res = 32'd0;
    case (f3)
      3'b000: alu_res = (opcode == OP_OP && ir[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001: alu_res = rs1_val << op_b[4:0];
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011: alu_res = {31'd0, rs1_val < op_b};
      3'b100: alu_res = rs1_val ^ op_b;
      3'b101: alu_res = ir[30] ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110: alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase
  end

  // Decode of the instruction held in ir: register writeback value, next pc, memory intent and legality.
  always_comb begin
    wr_en = 1'b0; wr_val = 32'd0; next_pc = pc + 32'd4; taken = 1'b0; br_cond = 1'b0;
    ill = 1'b0; is_mem = 1'b0; is_store = 1'b0; is_ebreak = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    case (opcode)
      OP_LUI:   begin use_rd = 1'b1; wr_en = 1'b1; wr_val = imm_u; end
      OP_AUIPC: begin use_rd = 1'b1; wr_en = 1'b1; wr_val = pc + imm_u; end
      OP_JAL: begin
        use_rd = 1'b1; wr_en = 1'b1; wr_val = pc + 32'd4;
        next_pc = pc + imm_j; taken = 1'b1;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1; wr_val = pc + 32'd4;
        next_pc = (rs1_val + imm_i) & ~32'd1; taken = 1'b1; ill = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000: br_cond = (rs1_val == rs2_val);
          3'b001: br_cond = (rs1_val != rs2_val);
          3'b100: br_cond = ($signed(rs1_val) < $signed(rs2_val));
          3'b101: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110: br_cond = (rs1_val < rs2_val);
          3'b111: br_cond = (rs1_val >= rs2_val);
          default: ill = 1'b1;
        endcase
        taken = br_cond;
        if (br_cond) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1;
        ill = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1; is_store = 1'b1;
        ill = !(f3 inside {3'b000, 3'b001, 3'b010});
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; wr_en = 1'b1; wr_val = alu_res;
        if (f3 == 3'b001) ill = (f7 != 7'h00);
        if (f3 == 3'b101) ill = (f7 != 7'h00 && f7 != 7'h20);
      end
      OP_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr_en = 1'b1; wr_val = alu_res;
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_FENCE: ill = (f3 != 3'b000);
      OP_SYSTEM: begin
        is_ebreak = (ir == 32'h0010_0073);
        ill       = !(ir == 32'h0000_0073 || is_ebreak);
      end
      default: ill = 1'b1;
    endcase
    if (use_rs1 && {1'b0, rs1} >= NREG_W) ill = 1'b1;
    if (use_rs2 && {1'b0, rs2} >= NREG_W) ill = 1'b1;
    if (use_rd  && {1'b0, rd}  >= NREG_W) ill = 1'b1;
    if (taken && next_pc[1]) ill = 1'b1;
    if (is_mem && f3[1:0] == 2'b01 && mem_addr[0]) ill = 1'b1;
    if (is_mem && f3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00) ill = 1'b1;
  end

  // Store lane steering, and load extraction from the returned word.
  always_comb begin
    st_data = rs2_val; st_strb = 4'b1111;
    case (f3[1:0])
      2'b00: begin st_data = {24'd0, rs2_val[7:0]} << {mem_addr[1:0], 3'b000}; st_strb = 4'b0001 << mem_addr[1:0]; end
      2'b01: begin st_data = {16'd0, rs2_val[15:0]} << {mem_addr[1:0], 3'b000}; st_strb = 4'b0011 << mem_addr[1:0]; end
      default: ;
    endcase
    ld_shift = bus.d_rdata >> {ld_off, 3'b000};
    case (f3)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_val = {24'd0, ld_shift[7:0]};
      3'b101:  ld_val = {16'd0, ld_shift[15:0]};
      default: ld_val = ld_shift;
    endcase
  end

  assign exec_commit = (state == S_EXEC) && !is_ebreak && !(ill && HALT_ILL) && !(is_mem && !ill);
  assign rf_we    = (rd != 5'd0) && ((exec_commit && wr_en && !ill) ||
                                     (state == S_MEM && bus.d_ack && !bus.d_we));
  assign rf_wdata = (state == S_MEM) ? ld_val : wr_val;

  // Register file writeback.
  always_ff @(posedge clk) begin
    // NOTE: the register file is a plain memory with no reset, so it stays out of the reset block.
    if (rf_we) rf[rd[IW-1:0]] <= rf_wdata;
  end

  // Control FSM with registered bus requests and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state in clocked blocks updates with <= so every reader sees pre-edge values.
    if (!rst) begin
      state <= S_FETCH; pc <= RESET_PC; ir <= 32'd0; ld_off <= 2'b00;
      bus.i_req <= 1'b0; bus.d_req <= 1'b0; bus.d_we <= 1'b0;
      bus.d_addr <= 32'd0; bus.d_wdata <= 32'd0; bus.d_wstrb <= 4'd0;
      retire <= 1'b0; halt <= 1'b0; illegal <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!bus.i_req) bus.i_req <= 1'b1;
          else if (bus.i_ack) begin
            ir <= bus.i_rdata; bus.i_req <= 1'b0; state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_ebreak) begin
            halt <= 1'b1; state <= S_HALT;
          end else if (ill && HALT_ILL) begin
            halt <= 1'b1; illegal <= 1'b1; state <= S_HALT;
          end else if (is_mem && !ill) begin
            bus.d_req <= 1'b1; bus.d_we <= is_store;
            bus.d_addr <= {mem_addr[31:2], 2'b00};
            bus.d_wdata <= st_data; bus.d_wstrb <= is_store ? st_strb : 4'd0;
            ld_off <= mem_addr[1:0]; state <= S_MEM;
          end else begin
            pc <= ill ? pc + 32'd4 : next_pc;
            retire <= 1'b1; bus.i_req <= 1'b1; state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.d_ack) begin
            bus.d_req <= 1'b0; pc <= pc + 32'd4;
            retire <= 1'b1; bus.i_req <= 1'b1; state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
